ft245_device: RTL and testbench

- Synthesizable model of the FTDI-chip end of the synchronous FT245 FIFO interface. It drives RXF#/TXE# and the data bus, and responds to RD#/WR#/OE#/SIWU# from our FPGA-side FT245 master.
- A host-side valid/ready byte stream stands in for the USB host.
- Used in loopback bring-up images and as the DUT partner in FT245 master benches. It holds one downstream (host->FPGA) buffer and one upstream (FPGA->host) buffer.

---
 rtl/ft245_pkg.sv | 15 +
 rtl/ft245_device_if.sv | 26 ++
 rtl/ft245_dev_fifo.sv | 48 ++++
 rtl/ft245_device.sv | 100 ++++++++++
 tb/tb_ft245_device.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 device model: bus width, error flag indices
// and the LFSR seed/taps used by the optional stall emulation.
package ft245_pkg;

  localparam int FT_DATA_W = 8;

  localparam int ERR_UNDERRUN   = 0;
  localparam int ERR_OVERRUN    = 1;
  localparam int ERR_CONTENTION = 2;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ft245_device_if.sv
// FT245 synchronous FIFO bus between the FPGA-side master and the device model.
// The device uses the slave modport, the FPGA side (or a bench) the master modport.
interface ft245_device_if;
  import ft245_pkg::*;

  logic [FT_DATA_W-1:0] ft_bus_in;
  logic [FT_DATA_W-1:0] ft_bus_out;
  logic                 ft_bus_oe;
  logic                 ft_rxf_n;
  logic                 ft_txe_n;
  logic                 ft_rd_n;
  logic                 ft_wr_n;
  logic                 ft_oe_n;
  logic                 ft_siwu_n;

  modport slave (
    input  ft_bus_in, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n,
    output ft_bus_out, ft_bus_oe, ft_rxf_n, ft_txe_n
  );

  modport master (
    output ft_bus_in, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n,
    input  ft_bus_out, ft_bus_oe, ft_rxf_n, ft_txe_n
  );

endinterface

// File: rtl/ft245_dev_fifo.sv
// First-word-fall-through synchronous FIFO with async active-high reset.
// Pointers carry one extra MSB so full and empty are distinguishable.
module ft245_dev_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/ft245_device.sv
// FTDI-side model of the synchronous FT245 FIFO interface with host byte streams.
// Define FT245_DEVICE_STALL_EN to add LFSR-driven pseudo-random RXF#/TXE# stalls.
module ft245_device
  import ft245_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 ft_clkout,
  input  logic                 rst,
  ft245_device_if.slave        ft,
  input  logic [FT_DATA_W-1:0] host_tx_data,
  input  logic                 host_tx_valid,
  output logic                 host_tx_ready,
  output logic [FT_DATA_W-1:0] host_rx_data,
  output logic                 host_rx_valid,
  input  logic                 host_rx_ready,
  output logic                 host_flush,
  output logic [2:0]           err_flags
);

  logic                 ready_q;
  logic                 siwu_q;
  logic                 stall;
  logic                 rxf_n;
  logic                 txe_n;
  logic                 rd_req;
  logic                 wr_req;
  logic                 ds_push, ds_pop, ds_full, ds_empty;
  logic                 us_push, us_pop, us_full, us_empty;
  logic [FT_DATA_W-1:0] ds_head, us_head;
  logic [DEPTH_LOG2:0]  ds_count, us_count;

  ft245_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(FT_DATA_W)) u_ds_fifo (
    .clk(ft_clkout), .rst(rst),
    .push(ds_push), .push_data(host_tx_data), .pop(ds_pop),
    .head_data(ds_head), .full(ds_full), .empty(ds_empty), .count(ds_count)
  );

  ft245_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(FT_DATA_W)) u_us_fifo (
    .clk(ft_clkout), .rst(rst),
    .push(us_push), .push_data(ft.ft_bus_in), .pop(us_pop),
    .head_data(us_head), .full(us_full), .empty(us_empty), .count(us_count)
  );

`ifdef FT245_DEVICE_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge ft_clkout or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
  end

  assign stall = (lfsr[2:0] == 3'b000);
`else
  assign stall = 1'b0;
`endif

  // Flags stay deasserted until the first edge after reset release
  assign rxf_n = ~ready_q | ds_empty | stall;
  assign txe_n = ~ready_q | us_full | stall;

  assign ft.ft_rxf_n   = rxf_n;
  assign ft.ft_txe_n   = txe_n;
  assign ft.ft_bus_oe  = ~ft.ft_oe_n;
  assign ft.ft_bus_out = (ds_count != '0) ? ds_head : '0;

  assign rd_req  = ~ft.ft_rd_n & ~ft.ft_oe_n;
  assign wr_req  = ~ft.ft_wr_n;
  assign ds_pop  = rd_req & ~rxf_n;
  assign us_push = wr_req & ~txe_n;

  assign host_tx_ready = ready_q & ~ds_full;
  assign ds_push       = host_tx_valid & host_tx_ready;
  assign host_rx_valid = ~us_empty;
  assign host_rx_data  = (us_count != '0) ? us_head : '0;
  assign us_pop        = host_rx_valid & host_rx_ready;

  always_ff @(posedge ft_clkout or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      siwu_q     <= 1'b1;
      host_flush <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      siwu_q     <= ft.ft_siwu_n;
      host_flush <= siwu_q & ~ft.ft_siwu_n;
    end
  end

  always_ff @(posedge ft_clkout or posedge rst) begin
    if (rst) begin
      err_flags <= '0;
    end else begin
      if (rd_req & rxf_n)         err_flags[ERR_UNDERRUN]   <= 1'b1;
      if (wr_req & txe_n)         err_flags[ERR_OVERRUN]    <= 1'b1;
      if (~ft.ft_oe_n & wr_req)   err_flags[ERR_CONTENTION] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft245_device.sv
// Directed bench for ft245_device: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/drain, SIWU flush and mid-transfer reset.
module tb_ft245_device;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic       host_flush;
  logic [2:0] err_flags;

  int n_vec  = 0;
  int n_miss = 0;

  ft245_device_if ft_if ();

  ft245_device #(.DEPTH_LOG2(4)) dut (
    .ft_clkout(clk), .rst(rst), .ft(ft_if.slave),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_flush(host_flush), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        rd_n;
    logic        oe_n;
    logic        wr_n;
    logic [7:0]  bus_in;
    logic        rx_ready;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output word: {rxf_n, txe_n, bus_oe, bus_out, tx_ready, rx_valid, rx_data, err, flush}
  function automatic logic [24:0] pack_out(logic rxf, logic txe, logic oe, logic [7:0] dout,
                                           logic txr, logic rxv, logic [7:0] rxd,
                                           logic [2:0] err, logic flush);
    return {rxf, txe, oe, dout, txr, rxv, rxd, err, flush};
  endfunction

  function automatic string fmt_out(logic [24:0] o);
    return $sformatf("rxf_n=%b txe_n=%b oe=%b out=%h txr=%b rxv=%b rxd=%h err=%b flush=%b",
                     o[24], o[23], o[22], o[21:14], o[13], o[12], o[11:4], o[3:1], o[0]);
  endfunction

  function automatic logic [24:0] sample_out();
    return {ft_if.ft_rxf_n, ft_if.ft_txe_n, ft_if.ft_bus_oe, ft_if.ft_bus_out,
            host_tx_ready, host_rx_valid, host_rx_data, err_flags, host_flush};
  endfunction

  function automatic void add_vec(string name, logic txv, logic [7:0] txd, logic rd_n,
                                  logic oe_n, logic wr_n, logic [7:0] bus_in, logic rxr,
                                  logic [24:0] exp);
    vec_t v;
    v.name = name; v.tx_valid = txv; v.tx_data = txd; v.rd_n = rd_n; v.oe_n = oe_n;
    v.wr_n = wr_n; v.bus_in = bus_in; v.rx_ready = rxr; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    host_tx_valid     = v.tx_valid;
    host_tx_data      = v.tx_data;
    ft_if.ft_rd_n     = v.rd_n;
    ft_if.ft_oe_n     = v.oe_n;
    ft_if.ft_wr_n     = v.wr_n;
    ft_if.ft_bus_in   = v.bus_in;
    host_rx_ready     = v.rx_ready;
  endtask

  task automatic idle_inputs();
    host_tx_valid   = 1'b0;
    host_tx_data    = 8'h00;
    ft_if.ft_rd_n   = 1'b1;
    ft_if.ft_oe_n   = 1'b1;
    ft_if.ft_wr_n   = 1'b1;
    ft_if.ft_bus_in = 8'h00;
    ft_if.ft_siwu_n = 1'b1;
    host_rx_ready   = 1'b0;
  endtask

  task automatic check_vector(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmt_out(act), fmt_out(exp));
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    int flush_cnt;

    // Single-cycle table: inputs held across one edge, outputs checked after it
    add_vec("idle_after_rst", 0, 8'h00, 1, 1, 1, 8'h00, 0, pack_out(1,0,0,8'h00,1,0,8'h00,3'b000,0));
    add_vec("push_11",        1, 8'h11, 1, 1, 1, 8'h00, 0, pack_out(0,0,0,8'h11,1,0,8'h00,3'b000,0));
    add_vec("push_22_oe",     1, 8'h22, 1, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h11,1,0,8'h00,3'b000,0));
    add_vec("push_33_oe",     1, 8'h33, 1, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h11,1,0,8'h00,3'b000,0));
    add_vec("pop_11",         0, 8'h00, 0, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h22,1,0,8'h00,3'b000,0));
    add_vec("pop_22",         0, 8'h00, 0, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h33,1,0,8'h00,3'b000,0));
    add_vec("pop_33_last",    0, 8'h00, 0, 0, 1, 8'h00, 0, pack_out(1,0,1,8'h00,1,0,8'h00,3'b000,0));
    add_vec("idle_empty",     0, 8'h00, 1, 1, 1, 8'h00, 0, pack_out(1,0,0,8'h00,1,0,8'h00,3'b000,0));
    add_vec("rd_when_empty",  0, 8'h00, 0, 0, 1, 8'h00, 0, pack_out(1,0,1,8'h00,1,0,8'h00,3'b001,0));
    add_vec("underrun_stick", 0, 8'h00, 1, 1, 1, 8'h00, 0, pack_out(1,0,0,8'h00,1,0,8'h00,3'b001,0));
    add_vec("push_pop_empty", 1, 8'h44, 0, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h44,1,0,8'h00,3'b001,0));
    add_vec("push_pop_same",  1, 8'h55, 0, 0, 1, 8'h00, 0, pack_out(0,0,1,8'h55,1,0,8'h00,3'b001,0));
    add_vec("pop_55",         0, 8'h00, 0, 0, 1, 8'h00, 0, pack_out(1,0,1,8'h00,1,0,8'h00,3'b001,0));
    add_vec("idle_2",         0, 8'h00, 1, 1, 1, 8'h00, 0, pack_out(1,0,0,8'h00,1,0,8'h00,3'b001,0));
    add_vec("contention_ab",  0, 8'h00, 1, 0, 0, 8'hAB, 0, pack_out(1,0,1,8'h00,1,1,8'hAB,3'b101,0));
    add_vec("host_take_ab",   0, 8'h00, 1, 1, 1, 8'h00, 1, pack_out(1,0,0,8'h00,1,0,8'h00,3'b101,0));

    idle_inputs();
    rst = 1'b1;
    #12;
    check_vector("reset_state", sample_out(), pack_out(1,1,0,8'h00,0,0,8'h00,3'b000,0));
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      tick();
      check_vector(vecs[i].name, sample_out(), vecs[i].exp);
    end
    idle_inputs();

    // Upstream fill to 16, overflow, then drain in order
    for (int i = 0; i < 16; i++) begin
      ft_if.ft_wr_n   = 1'b0;
      ft_if.ft_bus_in = 8'(i);
      tick();
      check_output($sformatf("txe_after_wr%0d", i), 32'(ft_if.ft_txe_n), (i == 15) ? 32'd1 : 32'd0);
    end
    check_output("rx_head_00", 32'(host_rx_data), 32'h00);
    ft_if.ft_bus_in = 8'hFF;
    tick();
    check_output("overrun_err", 32'(err_flags), 32'b111);
    check_output("txe_still_full", 32'(ft_if.ft_txe_n), 32'd1);
    ft_if.ft_wr_n = 1'b1;
    host_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("drain_%0d", i), {23'd0, host_rx_valid, host_rx_data}, {23'd0, 1'b1, 8'(i)});
      tick();
    end
    check_output("drained_empty", 32'(host_rx_valid), 32'd0);
    check_output("txe_after_drain", 32'(ft_if.ft_txe_n), 32'd0);
    host_rx_ready = 1'b0;

    // SIWU# low for three cycles gives exactly one flush pulse
    flush_cnt = 0;
    ft_if.ft_siwu_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) ft_if.ft_siwu_n = 1'b1;
      tick();
      if (i == 0) check_output("flush_first_edge", 32'(host_flush), 32'd1);
      if (host_flush) flush_cnt++;
    end
    check_output("flush_pulse_count", 32'(flush_cnt), 32'd1);

    // Buffer five bytes each way, then reset while transfers are still active
    for (int i = 0; i < 5; i++) begin
      host_tx_valid   = 1'b1;
      host_tx_data    = 8'h60 + 8'(i);
      ft_if.ft_wr_n   = 1'b0;
      ft_if.ft_bus_in = 8'h70 + 8'(i);
      tick();
    end
    check_vector("five_each_way", sample_out(), pack_out(0,0,0,8'h60,1,1,8'h70,3'b111,0));
    #2 rst = 1'b1;
    #1;
    check_vector("mid_xfer_reset", sample_out(), pack_out(1,1,0,8'h00,0,0,8'h00,3'b000,0));
    idle_inputs();
    #3 rst = 1'b0;
    tick();
    check_vector("after_release", sample_out(), pack_out(1,0,0,8'h00,1,0,8'h00,3'b000,0));
    tick();
    check_vector("no_residue", sample_out(), pack_out(1,0,0,8'h00,1,0,8'h00,3'b000,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
